// File: rtl/mcycle_if.sv
// Operation request/result bundle between the core and the multi-cycle multiply/divide unit.
interface mcycle_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (output Start, MCycleOp, Operand1, Operand2,
                  input  Result1, Result2, Busy, Done);
  modport slave  (input  Start, MCycleOp, Operand1, Operand2,
                  output Result1, Result2, Busy, Done);
endinterface

// File: rtl/mcycle.sv
// Iterative multiply (shift-add) / divide (restoring) unit: one bit per clock on operand magnitudes,
// sign fix-up applied on the edge that enters DONE.
module mcycle #(
  parameter int WIDTH = 32
) (
  input  logic  CLK,
  input  logic  Reset,
  mcycle_if.slave bus
);
  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST      = CW'(WIDTH - 1);
  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_COMPUTE = 2'd1;
  localparam logic [1:0]    S_DONE    = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] res1, res2;

  logic             accept, is_div, is_sgn;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] hi_nx, lo_nx, fin1, fin2;
  logic [2*WIDTH-1:0] prod;

  // Unsigned magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept = bus.Start && (state == S_IDLE || state == S_DONE);
  assign is_div = op_q[1];
  assign is_sgn = op_q[0];
  assign mag1   = mag(op1_q, is_sgn);
  assign mag2   = mag(op2_q, is_sgn);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hi_nx   = hi;
    lo_nx   = lo;
    fin1    = '0;
    fin2    = '0;
    sum     = {1'b0, hi} + {1'b0, (lo[0] ? mag1 : '0)};
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, mag2};
    diff    = shifted[WIDTH-1:0] - mag2;
    if (is_div) begin
      hi_nx = ge ? diff : shifted[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end
    prod = {hi_nx, lo_nx};
    if (is_div) begin
      if (op2_q == '0) begin
        fin1 = '1;
        fin2 = op1_q;
      end else begin
        fin1 = (is_sgn && (op1_q[WIDTH-1] ^ op2_q[WIDTH-1])) ? -lo_nx : lo_nx;
        fin2 = (is_sgn && op1_q[WIDTH-1]) ? -hi_nx : hi_nx;
      end
    end else begin
      if (is_sgn && (op1_q[WIDTH-1] ^ op2_q[WIDTH-1])) prod = -prod;
      {fin2, fin1} = prod;
    end
  end

  // NOTE: all state, including latched operands and results, is cleared by reset so an
  // aborted operation leaves no stale data visible.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      op1_q <= '0;
      op2_q <= '0;
      hi    <= '0;
      lo    <= '0;
      res1  <= '0;
      res2  <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register update in this block edge-consistent.
      state <= S_COMPUTE;
      cnt   <= '0;
      op_q  <= bus.MCycleOp;
      op1_q <= bus.Operand1;
      op2_q <= bus.Operand2;
      hi    <= '0;
      lo    <= bus.MCycleOp[1] ? mag(bus.Operand1, bus.MCycleOp[0])
                               : mag(bus.Operand2, bus.MCycleOp[0]);
    end else begin
      case (state)
        S_COMPUTE: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= S_DONE;
            res1  <= fin1;
            res2  <= fin2;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy    = (state == S_COMPUTE) || accept;
  assign bus.Done    = (state == S_DONE);
  assign bus.Result1 = res1;
  assign bus.Result2 = res2;
endmodule

// File: tb/tb_mcycle.sv
// Directed bench for mcycle: multiply/divide vectors, boundary cases, back-to-back Start and reset abort.
module tb_mcycle;
  logic CLK   = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  mcycle_if #(.WIDTH(32)) bus ();
  mcycle #(.WIDTH(32)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input logic [63:0] got, input logic [63:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Counts negedges from the cycle after the accepting edge until Done, and how many had Busy.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    @(negedge CLK);
    while (!bus.Done && cyc < 40) begin
      cyc++;
      if (bus.Busy) busy_cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2, input string tag);
    int cyc, bc;
    @(negedge CLK);
    bus.Start = 1'b1; bus.MCycleOp = op; bus.Operand1 = a; bus.Operand2 = b;
    #1 check(64'(bus.Busy), 64'd1, {tag, " busy_on_start"});
    @(posedge CLK);
    #1 bus.Start = 1'b0; bus.Operand1 = ~a; bus.Operand2 = ~b; bus.MCycleOp = ~op;
    wait_done(cyc, bc);
    check(64'(cyc), 64'd32, {tag, " latency"});
    check(64'(bc), 64'd32, {tag, " busy_cycles"});
    check({bus.Result2, bus.Result1}, {e2, e1}, {tag, " result"});
    check(64'(bus.Busy), 64'd0, {tag, " busy_in_done"});
    @(negedge CLK);
    check(64'(bus.Done), 64'd0, {tag, " done_one_cycle"});
    check({bus.Result2, bus.Result1}, {e2, e1}, {tag, " result_hold"});
  endtask

  initial begin
    int cyc, bc, seen;
    bus.Start = 1'b0; bus.MCycleOp = 2'b00; bus.Operand1 = '0; bus.Operand2 = '0;
    repeat (2) @(negedge CLK);
    check({62'd0, bus.Busy, bus.Done}, 64'd0, "reset busy_done");
    check({bus.Result2, bus.Result1}, 64'd0, "reset results");
    Reset = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, "umul_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, "smul_m3x7");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, "smul_minmin");
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "smul_m1xmin");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, "sdiv_m7d2");
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, "sdiv_7dm2");
    run_op(2'b10, 32'd100,       32'd7,         32'd14,        32'd2,         "udiv_100d7");
    run_op(2'b10, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      "udiv_by0");
    run_op(2'b11, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 32'h8000_0000, "sdiv_by0");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, "sdiv_min_m1");

    // Start held high: operands change mid-COMPUTE, second op launches straight from DONE.
    @(negedge CLK);
    bus.Start = 1'b1; bus.MCycleOp = 2'b00; bus.Operand1 = 32'd3; bus.Operand2 = 32'd5;
    @(posedge CLK);
    #1 bus.Operand1 = 32'd6; bus.Operand2 = 32'd7;
    wait_done(cyc, bc);
    check(64'(cyc), 64'd32, "b2b first latency");
    check({bus.Result2, bus.Result1}, 64'd15, "b2b first result");
    check(64'(bus.Busy), 64'd1, "b2b busy_in_done");
    @(posedge CLK);
    #1 bus.Start = 1'b0;
    wait_done(cyc, bc);
    check(64'(cyc), 64'd32, "b2b second latency");
    check(64'(bc), 64'd32, "b2b second busy_cycles");
    check({bus.Result2, bus.Result1}, 64'd42, "b2b second result");

    // Reset pulsed during iteration 10 of a divide.
    @(negedge CLK);
    bus.Start = 1'b1; bus.MCycleOp = 2'b10; bus.Operand1 = 32'd100; bus.Operand2 = 32'd7;
    @(posedge CLK);
    #1 bus.Start = 1'b0;
    repeat (10) @(negedge CLK);
    check(64'(bus.Busy), 64'd1, "abort busy_before");
    #1 Reset = 1'b0;
    #1 check({62'd0, bus.Busy, bus.Done}, 64'd0, "abort busy_done");
    check({bus.Result2, bus.Result1}, 64'd0, "abort results");
    @(negedge CLK);
    Reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.Done || bus.Busy) seen++;
    end
    check(64'(seen), 64'd0, "abort no_done");
    check({bus.Result2, bus.Result1}, 64'd0, "abort results_stay");
    run_op(2'b10, 32'd100, 32'd7, 32'd14, 32'd2, "post_reset_udiv");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mcycle.md
MCYCLE -- requirements
Module: mcycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1; reset is asynchronous and active-low (0 = reset).
REQ-004 SHALL have port Start, input, 1, a request to begin an operation, sampled on the rising edge.
REQ-005 SHALL have port MCycleOp, input, 2: 00 unsigned multiply, 01 signed multiply, 10 unsigned divide, 11 signed divide.
REQ-006 SHALL have ports Operand1 and Operand2, input, WIDTH each: multiplicand/multiplier, or dividend/divisor.
REQ-007 SHALL have port Result1, output, WIDTH: low product half, or quotient.
REQ-008 SHALL have port Result2, output, WIDTH: high product half, or remainder.
REQ-009 SHALL have port Busy, output, 1, the stall request consumed by the core to hold the PC and register writes.
REQ-010 SHALL have port Done, output, 1, a one-cycle pulse marking Result1/Result2 as newly valid.

Function
REQ-011 SHALL implement an FSM with states IDLE, COMPUTE and DONE.
REQ-012 SHALL accept Start only in IDLE or DONE; on an accepting edge it latches Operand1, Operand2 and MCycleOp, clears the iteration counter, and enters COMPUTE.
REQ-013 SHALL drive Busy combinationally high when Start=1 in IDLE or DONE, and high throughout COMPUTE; Busy is low otherwise.
REQ-014 SHALL ignore Start and any operand/op changes while in COMPUTE, using only the latched values.
REQ-015 SHALL perform exactly one iteration per clock in COMPUTE: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-016 SHALL leave COMPUTE for DONE on the edge completing iteration WIDTH, so Start at edge E0 gives Done=1 in the cycle following edge E0+WIDTH.
REQ-017 SHALL assert Done for exactly one cycle in DONE; Busy=0 in that cycle unless a new Start is presented.
REQ-018 SHALL return from DONE to IDLE on the next edge when Start=0, or re-enter COMPUTE when Start=1.
REQ-019 SHALL update Result1/Result2 only on the edge entering DONE, holding them stable until the next DONE entry.
REQ-020 Multiply SHALL produce the full 2*WIDTH product as {Result2,Result1}; for signed multiply, operands are taken as magnitudes and the product is two's-complement negated when the operand signs differ.
REQ-021 Unsigned divide SHALL give Result1=floor(Op1/Op2) and Result2=Op1 mod Op2.
REQ-022 Signed divide SHALL truncate toward zero: quotient sign = sign(Op1) XOR sign(Op2); remainder sign = sign(Op1).
REQ-023 Divide by zero (Op2=0) SHALL give Result1=all ones and Result2=Operand1 unchanged, for both signed and unsigned divide, with normal latency.
REQ-024 Signed -2^(WIDTH-1) / -1 SHALL give Result1=0x80000000 (WIDTH=32) and Result2=0.
REQ-025 The most-negative operand SHALL be handled in signed multiply, with its magnitude 2^(WIDTH-1) represented without overflow.

Reset
REQ-026 Reset=0 SHALL immediately force IDLE, Busy=0, Done=0, Result1=0, Result2=0, counter=0, and latched operands=0, independent of CLK.
REQ-027 Reset asserted mid-COMPUTE SHALL abort the operation; no Done pulse follows and results stay 0.
REQ-028 After Reset deasserts, the first accepting edge with Start=1 SHALL behave as REQ-012.

Verification
REQ-029 Unsigned multiply 0xFFFFFFFF x 0xFFFFFFFF -> Busy high 32 cycles, Done 1 cycle later, Result2=0xFFFFFFFE, Result1=0x00000001.
REQ-030 Signed multiply -3 x 7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB; signed multiply 0x80000000 x 0x80000000 -> Result2=0x40000000, Result1=0.
REQ-031 Signed divide -7 / 2 -> Result1=0xFFFFFFFD (-3), Result2=0xFFFFFFFF (-1); unsigned divide 100 / 7 -> 14, 2.
REQ-032 Divide by zero 0x1234 / 0 -> Result1=0xFFFFFFFF, Result2=0x1234; signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, 0.
REQ-033 Start held high continuously, with operands changed mid-COMPUTE -> results reflect only the latched operands; a new operation starts from DONE with no IDLE gap.
REQ-034 Reset pulsed low at iteration 10 of a divide -> Busy drops immediately, no Done pulse, outputs 0; the next Start completes normally.
